multicycle_sub: RTL and testbench

MULTICYCLE_SUB -- requirements
Module: multicycle_sub

---
 rtl/sub_pkg.sv | 13 +
 rtl/sub_slice.sv | 21 ++
 rtl/multicycle_sub.sv | 106 ++++++++++
 tb/tb_multicycle_sub.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the multi-cycle subtractor: FSM state type and default geometry.
package sub_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned DefWidth = 16;
   localparam int unsigned DefChunk = 4;

endpackage

// File: rtl/sub_slice.sv
// Combinational CHUNK-bit subtract slice: diff = a - b - borrow_in, with borrow out.
module sub_slice #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             borrow_i,
   output logic [CHUNK-1:0] diff_o,
   output logic             borrow_o
);

   logic [CHUNK:0] full;

   // One extra bit: the result goes negative exactly when a borrow leaves the slice.
   always_comb begin
      full     = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, borrow_i};
      diff_o   = full[CHUNK-1:0];
      borrow_o = full[CHUNK];
   end

endmodule

// File: rtl/multicycle_sub.sv
// Multi-cycle subtractor: latches operands on start, then resolves one CHUNK-bit slice per clock.
module multicycle_sub
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CHUNK = DefChunk
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bor,
   output logic             ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_e           state_q;
   logic [IdxW-1:0]  idx_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, diff_q;
   logic             sm_q, borrow_q, bor_q, ovf_q;

   logic [CHUNK-1:0] sl_a, sl_b, sl_diff;
   logic             sl_bout;
   logic [WIDTH-1:0] acc_next;
   logic             last_slice;
   logic             ovf_next;

   always_comb begin
      sl_a       = a_q[idx_q*CHUNK +: CHUNK];
      sl_b       = b_q[idx_q*CHUNK +: CHUNK];
      acc_next   = acc_q;
      acc_next[idx_q*CHUNK +: CHUNK] = sl_diff;
      last_slice = (idx_q == IdxW'(NCHUNK - 1));
      ovf_next   = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (acc_next[WIDTH-1] ^ a_q[WIDTH-1]);
   end

   sub_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a_i      (sl_a),
      .b_i      (sl_b),
      .borrow_i (borrow_q),
      .diff_o   (sl_diff),
      .borrow_o (sl_bout)
   );

   // acc_q collects partial slices privately; diff_q only changes on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         diff_q   <= '0;
         sm_q     <= 1'b0;
         borrow_q <= 1'b0;
         bor_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  sm_q     <= signed_mode;
                  idx_q    <= '0;
                  acc_q    <= '0;
                  state_q  <= StRun;
               end else begin
                  state_q  <= StIdle;
               end
            end
            StRun: begin
               acc_q    <= acc_next;
               borrow_q <= sl_bout;
               idx_q    <= idx_q + IdxW'(1);
               if (last_slice) begin
                  diff_q  <= acc_next;
                  bor_q   <= sl_bout;
                  ovf_q   <= ovf_next;
                  idx_q   <= '0;
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign diff = diff_q;
   assign bor  = bor_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_sub.sv
// Directed bench for multicycle_sub at 16/4, plus an exhaustive 4-bit sweep at CHUNK 1, 2 and 4.
module tb_multicycle_sub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        bin = 1'b0, signed_mode = 1'b0;
   logic        busy, done, bor, ovf;
   logic [15:0] diff;

   logic       s_start = 1'b0, s_bin = 1'b0, s_sm = 1'b0;
   logic [3:0] s_a = '0, s_b = '0;
   logic       busy1, done1, bor1, ovf1;
   logic       busy2, done2, bor2, ovf2;
   logic       busy4, done4, bor4, ovf4;
   logic [3:0] diff1, diff2, diff4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_sub #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .signed_mode(signed_mode), .busy(busy), .done(done), .diff(diff), .bor(bor), .ovf(ovf)
   );

   multicycle_sub #(.WIDTH(4), .CHUNK(1)) dut_c1 (
      .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .bin(s_bin),
      .signed_mode(s_sm), .busy(busy1), .done(done1), .diff(diff1), .bor(bor1), .ovf(ovf1)
   );

   multicycle_sub #(.WIDTH(4), .CHUNK(2)) dut_c2 (
      .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .bin(s_bin),
      .signed_mode(s_sm), .busy(busy2), .done(done2), .diff(diff2), .bor(bor2), .ovf(ovf2)
   );

   multicycle_sub #(.WIDTH(4), .CHUNK(4)) dut_c4 (
      .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .bin(s_bin),
      .signed_mode(s_sm), .busy(busy4), .done(done4), .diff(diff4), .bor(bor4), .ovf(ovf4)
   );

   task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic binv,
                         input logic smv);
      @(negedge clk);
      a = av; b = bv; bin = binv; signed_mode = smv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // lat counts negedges after the one following the start-sampling edge.
   task automatic wait_done(output int lat, output int bcnt);
      lat = 0;
      bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, diff, bor, ovf} !== 19'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b diff=%h bor=%b ovf=%b, want all 0",
                  busy, done, diff, bor, ovf);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, bc;
      launch(16'h1234, 16'h0234, 1'b0, 1'b0);
      wait_done(lat, bc);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
      checks++;
      if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
      checks++;
      if ({diff, bor, ovf} !== {16'h1000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_result: got diff=%h bor=%b ovf=%b want 1000 0 0", diff, bor, ovf);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || diff !== 16'h1000) begin
         errors++;
         $display("FAIL basic_done_pulse: got done=%b diff=%h want 0 1000", done, diff);
      end
   endtask

   task automatic test_borrow();
      int lat, bc;
      logic [15:0] av [3] = '{16'h0000, 16'h5555, 16'h5555};
      logic [15:0] bv [3] = '{16'h0001, 16'h5555, 16'h5554};
      logic        cv [3] = '{1'b0, 1'b1, 1'b1};
      logic [16:0] ev [3] = '{{16'hFFFF, 1'b1}, {16'hFFFF, 1'b1}, {16'h0000, 1'b0}};
      for (int i = 0; i < 3; i++) begin
         launch(av[i], bv[i], cv[i], 1'b0);
         wait_done(lat, bc);
         checks++;
         if ({diff, bor} !== ev[i] || lat !== 4) begin
            errors++;
            $display("FAIL borrow_%0d: got diff=%h bor=%b lat=%0d want diff=%h bor=%b lat=4",
                     i, diff, bor, lat, ev[i][16:1], ev[i][0]);
         end
      end
   endtask

   task automatic test_ovf();
      int lat, bc;
      launch(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done(lat, bc);
      checks++;
      if ({diff, bor, ovf} !== {16'h7FFF, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL ovf_signed: got diff=%h bor=%b ovf=%b want 7fff 0 1", diff, bor, ovf);
      end
      launch(16'h8000, 16'h0001, 1'b0, 1'b0);
      wait_done(lat, bc);
      checks++;
      if ({diff, bor, ovf} !== {16'h7FFF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL ovf_unsigned: got diff=%h bor=%b ovf=%b want 7fff 0 0", diff, bor, ovf);
      end
   endtask

   task automatic test_ignore_busy();
      int lat, bc;
      launch(16'h1234, 16'h0234, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (diff !== 16'h7FFF || busy !== 1'b1) begin
         errors++;
         $display("FAIL no_partial: got diff=%h busy=%b want 7fff 1", diff, busy);
      end
      a = 16'hFFFF; b = 16'h0001; bin = 1'b1; signed_mode = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      checks++;
      if (lat !== 1 || {diff, bor, ovf} !== {16'h1000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL ignore_start: got lat=%0d diff=%h bor=%b ovf=%b want 1 1000 0 0",
                  lat, diff, bor, ovf);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ignore_no_restart: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      @(negedge clk);
      a = 16'h00FF; b = 16'h0001; bin = 1'b0; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 16'hABCD; b = 16'h1111;
      wait_done(lat, bc);
      checks++;
      if (lat !== 4 || diff !== 16'h00FE) begin
         errors++;
         $display("FAIL b2b_first: got lat=%0d diff=%h want 4 00fe", lat, diff);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_restart: got done=%b busy=%b want 0 1", done, busy);
      end
      wait_done(lat, bc);
      checks++;
      if (lat !== 4 || {diff, bor, ovf} !== {16'h9ABC, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL b2b_second: got lat=%0d diff=%h bor=%b ovf=%b want 4 9abc 0 0",
                  lat, diff, bor, ovf);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat, bc;
      logic saw_done;
      launch(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, diff, bor, ovf} !== 19'd0) begin
         errors++;
         $display("FAIL reset_async: got busy=%b done=%b diff=%h bor=%b ovf=%b want all 0",
                  busy, done, diff, bor, ovf);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: got done pulse=%b want 0", saw_done);
      end
      launch(16'h0003, 16'h0005, 1'b0, 1'b1);
      wait_done(lat, bc);
      checks++;
      if (lat !== 4 || {diff, bor, ovf} !== {16'hFFFE, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_recover: got lat=%0d diff=%h bor=%b ovf=%b want 4 fffe 1 0",
                  lat, diff, bor, ovf);
      end
   endtask

   task automatic test_sweep();
      int l1, l2, l4;
      logic [4:0] full;
      logic [3:0] av, bv;
      logic       ev_ovf;
      logic [5:0] exp_v;
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               av = 4'(ai);
               bv = 4'(bi);
               @(negedge clk);
               s_a = av; s_b = bv; s_bin = ci[0]; s_sm = 1'b1; s_start = 1'b1;
               @(negedge clk);
               s_start = 1'b0;
               checks++;
               if ({busy1, busy2, busy4} !== 3'b111) begin
                  errors++;
                  $display("FAIL sweep_busy a=%h b=%h bin=%0d: got %b want 111",
                           av, bv, ci, {busy1, busy2, busy4});
               end
               l1 = -1; l2 = -1; l4 = -1;
               for (int k = 0; k < 10; k++) begin
                  if (done1 && l1 < 0) l1 = k;
                  if (done2 && l2 < 0) l2 = k;
                  if (done4 && l4 < 0) l4 = k;
                  if (l1 >= 0 && l2 >= 0 && l4 >= 0) break;
                  @(negedge clk);
               end
               full   = {1'b0, av} - {1'b0, bv} - 5'(ci);
               ev_ovf = (av[3] != bv[3]) && (full[3] != av[3]);
               exp_v  = {full[3:0], full[4], ev_ovf};
               checks++;
               if (l1 != 4 || l2 != 2 || l4 != 1) begin
                  errors++;
                  $display("FAIL sweep_latency a=%h b=%h bin=%0d: got %0d/%0d/%0d want 4/2/1",
                           av, bv, ci, l1, l2, l4);
               end
               checks++;
               if ({diff1, bor1, ovf1} !== exp_v || {diff2, bor2, ovf2} !== exp_v ||
                   {diff4, bor4, ovf4} !== exp_v) begin
                  errors++;
                  $display("FAIL sweep_result a=%h b=%h bin=%0d: got %h/%h/%h want %h",
                           av, bv, ci, {diff1, bor1, ovf1}, {diff2, bor2, ovf2},
                           {diff4, bor4, ovf4}, exp_v);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_borrow();
      test_ovf();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_run();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
